freq_meter: RTL
===============

// Module: freq_meter
// PURPOSE
//  Measures the frequency of an external digital signal by counting its rising edges over a fixed gate window of clk cycles.
//  It is the inverse of the display clock divider: the divider derives slow strobes from clk, this block reports an unknown
//  input rate in clk units. The result feeds the seven-segment display path (edges per gate = Hz when the gate is 1 s).
//  Measurement runs continuously while enabled, with back-to-back windows and no dead cycles.
// PARAMETERS
//  GATE_CYCLES  100_000_000  gate window length in clk cycles (>=2); 1 s at 100 MHz
//  CNT_W        27           width of edge counter and result
// PORTS
//  clk     in   1      system clock; the only clock
//  arst    in   1      reset: synchronous, active-high (sampled on posedge clk only)
//  en      in   1      measurement enable (level)
//  sig_in  in   1      signal under measurement
//  count   out  CNT_W  rising edges in last completed window
//  valid   out  1      one-cycle pulse: count/ovf updated this cycle
//  ovf     out  1      last completed window saturated the edge counter
//  busy    out  1      window in progress (state == GATE)
// BEHAVIOUR
//  - Reset (arst=1 at posedge clk): count=0, valid=0, ovf=0, busy=0, state=IDLE, gate/edge counters=0, edge-det history=1.
//  - Reset mid-window: window discarded, no valid; outputs return to reset values on the next edge.
//  - Edge detect: edge = s & ~s_d (s = conditioned sig_in, s_d = s one cycle later); runs every cycle in all states.
//    History resets to 1, so sig_in held high through reset is not counted as an edge.
//  - FSM, 2 states:
//    IDLE: busy=0. If en=1 -> GATE next cycle, gate_cnt=0, edge_cnt=0. Edges in IDLE are ignored.
//    GATE: busy=1. Each cycle gate_cnt+=1; edge_cnt+=edge (saturates at 2^CNT_W-1; a sticky ovf_int sets on saturation).
//      At the terminal cycle (gate_cnt==GATE_CYCLES-1):
//      count<=edge_cnt+edge (saturated), ovf<=ovf_int|sat, valid<=1 for 1 cycle;
//      counters and ovf_int clear; stay in GATE if en=1, else IDLE.
//      An edge in the terminal cycle counts toward the closing window, never the next one.
//    en=0 in a non-terminal GATE cycle: abort -> IDLE; no valid; count/ovf hold the previous result.
//  - The window is exactly GATE_CYCLES cycles; consecutive windows are contiguous with no gap.
//  - Latency: valid rises the cycle after the terminal cycle's posedge, i.e. registered. The sig_in-to-counted delay is
//    the conditioner latency (below).
//  - Max measurable rate: clk/2 (sig_in toggling every cycle). Faster inputs alias; this is not detected.
//  - count/ovf change only when valid=1.
// CONFIGURATION
//  FREQ_METER_SYNC_EN defined: sig_in passes a 2-flop synchronizer (reset to 1) before the edge detector. This adds
//    2 cycles of latency. Required for an asynchronous sig_in.
//  Not defined: sig_in is taken as synchronous to clk and feeds the edge detector directly (no added latency).
// STRUCTURE
//  - freq_meter_pkg (shared header): state encodings ST_IDLE/ST_GATE, and the gate counter width function
//    GATE_W = $clog2(GATE_CYCLES).
//  - Sub-module freq_meter_edge_det: optional synchronizer plus edge register, outputs edge. It holds the
//    FREQ_METER_SYNC_EN switch.
//  - The top level holds the FSM, gate counter, saturating edge counter and output registers.
// TESTING (sim: GATE_CYCLES=100, CNT_W=8, both macro settings)
//  1. en=1, sig_in period 10 clk (5 high/5 low) -> valid every 100 cycles, count=10, ovf=0, busy stays 1.
//  2. sig_in constant 1 through and after reset, en=1 -> count=0 every window. Constant 0 -> count=0.
//  3. CNT_W=3, sig_in toggling each clk (50 edges/window) -> count=7, ovf=1. Next window at period 20 -> count=5, ovf=0.
//  4. Hold count=10, then drop en at cycle 40 of a window -> no valid; busy=0 next cycle; count stays 10.
//     Re-raise en -> a new full 100-cycle window.
//  5. arst=1 for 1 cycle at cycle 60 of a window -> count=0, ovf=0, valid=0. The next window, with en still 1,
//     reports a full result.
//  6. Single rising edge placed in the terminal cycle -> counted in the closing window (count=1); the next window
//     excludes it (count=0).

Source files
------------

// File: rtl/freq_meter_pkg.sv
// ============================================================================
//  Module      : freq_meter_pkg
//  Description : Shared state encodings and gate-counter sizing for freq_meter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package freq_meter_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_GATE = 1'b1;

    // Width that holds 0 .. gate_cycles-1; never narrower than one bit.
    function automatic int gate_w(input int gate_cycles);
        return (gate_cycles > 2) ? $clog2(gate_cycles) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/freq_meter_edge_det.sv
// ============================================================================
//  Module      : freq_meter_edge_det
//  Description : Rising-edge detector for the measured signal, with an
//                optional 2-flop synchronizer (FREQ_METER_SYNC_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_meter_edge_det (
    input  logic clk,
    input  logic arst,
    input  logic i_sig,
    output logic o_rise
);

    logic w_s;
    logic r_s_d;

`ifdef FREQ_METER_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Reset high so a signal already high out of reset reads as "no edge".
    always_ff @(posedge clk) begin
        if (arst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_sig;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = i_sig;
`endif

    always_ff @(posedge clk) begin
        if (arst) begin
            r_s_d <= 1'b1;
        end else begin
            r_s_d <= w_s;
        end
    end

    assign o_rise = w_s & ~r_s_d;

endmodule

`default_nettype wire

// File: rtl/freq_meter.sv
// ============================================================================
//  Module      : freq_meter
//  Description : Counts rising edges of sig_in over back-to-back windows of
//                GATE_CYCLES clocks. Build option: FREQ_METER_SYNC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W       = 27
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             ovf,
    output logic             busy
);

    localparam int                  c_gate_w    = gate_w(GATE_CYCLES);
    localparam logic [c_gate_w-1:0] c_gate_last = c_gate_w'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_cnt_max   = '1;

    state_t              r_state;
    logic [c_gate_w-1:0] r_gate_cnt;
    logic [CNT_W-1:0]    r_edge_cnt;
    logic                r_ovf_int;
    logic [CNT_W-1:0]    r_count;
    logic                r_valid;
    logic                r_ovf;
    logic                r_busy;

    logic                w_rise;
    logic                w_sat;
    logic [CNT_W-1:0]    w_edge_next;

    freq_meter_edge_det u_edge_det (
        .clk    (clk),
        .arst   (arst),
        .i_sig  (sig_in),
        .o_rise (w_rise)
    );

    // An edge arriving while the counter is already full is the overflow.
    assign w_sat       = w_rise & (r_edge_cnt == c_cnt_max);
    assign w_edge_next = w_sat ? r_edge_cnt : r_edge_cnt + CNT_W'(w_rise);

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state    <= ST_IDLE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_int  <= 1'b0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state    <= ST_GATE;
                        r_busy     <= 1'b1;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf_int  <= 1'b0;
                    end
                end
                ST_GATE: begin
                    if (r_gate_cnt == c_gate_last) begin
                        // Terminal edge belongs to the closing window.
                        r_count    <= w_edge_next;
                        r_ovf      <= r_ovf_int | w_sat;
                        r_valid    <= 1'b1;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf_int  <= 1'b0;
                        if (!en) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (!en) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf_int  <= 1'b0;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + c_gate_w'(1);
                        r_edge_cnt <= w_edge_next;
                        r_ovf_int  <= r_ovf_int | w_sat;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign count = r_count;
    assign valid = r_valid;
    assign ovf   = r_ovf;
    assign busy  = r_busy;

endmodule

`default_nettype wire
